// File: rtl/io_bus_pkg.sv
// Shared types and constants for the peripheral io bus initiator.
package io_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } io_state_e;

    // Register offsets of the peripherals decoded behind this master
    localparam int unsigned GPIO_CONFIG_OFS    = 0;
    localparam int unsigned GPIO_SET_OFS       = 4;
    localparam int unsigned GPIO_READ_OFS      = 8;
    localparam int unsigned GPIO_INT_READ_OFS  = 12;
    localparam int unsigned GPIO_INT_CLEAR_OFS = 16;

    // A zero timeout still needs a 1-bit counter to keep the port widths legal
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/io_timeout_counter.sv
// Saturating up-counter flagging the last allowed wait cycle; TIMEOUT_CYCLES=0 never expires.
module io_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && (count_q == CNT_W'(LAST));

endmodule

// File: rtl/io_bus_master.sv
// Single-outstanding io bus initiator: CPU valid/ready request in, one strobed access, registered response.
//  state   | meaning
//  IDLE    | req_ready high, waiting for a CPU request
//  ACCESS  | strobe held, waiting for io_ready or timeout
//  RESP    | resp_valid held until the CPU takes it
//  RECOVER | waiting for the responder to drop io_ready
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              io_clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] io_addr,
    output logic              io_read,
    output logic              io_write,
    output logic [DATA_W-1:0] io_wdata,
    output logic              read_ready,
    input  logic [DATA_W-1:0] io_rdata,
    input  logic              io_ready
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    io_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              read_ready_q, read_ready_d;
    logic              cnt_clear, cnt_en, expired;

    io_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk_i     (io_clk),
        .rst_i     (rst),
        .clear_i   (cnt_clear),
        .enable_i  (cnt_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        read_ready_d = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    rd_d        = !req_write;
                    wr_d        = req_write;
                    req_ready_d = 1'b0;
                    cnt_clear   = 1'b1;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // io_ready takes priority over a timeout landing in the same cycle
                if (io_ready) begin
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    rdata_d      = wr_q ? '0 : io_rdata;
                    read_ready_d = rd_q;
                    err_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (expired) begin
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    rdata_d      = '0;
                    err_d        = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    rdata_d      = '0;
                    err_d        = 1'b0;
                    cnt_clear    = 1'b1;
                    if (io_ready) begin
                        state_d = ST_RECOVER;
                    end else begin
                        req_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_RECOVER: begin
                if (!io_ready || expired) begin
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge io_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            read_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            read_ready_q <= read_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign io_addr    = addr_q;
    assign io_wdata   = wdata_q;
    assign io_read    = rd_q;
    assign io_write   = wr_q;
    assign read_ready = read_ready_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: responder model with configurable latency, reference model of response/latency rules.
module tb_io_bus_master;
    import io_bus_pkg::*;

    localparam int T = 8;

    logic        io_clk, rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] io_addr, io_wdata, io_rdata;
    logic        io_read, io_write, read_ready, io_ready;

    int errors = 0;
    int checks = 0;

    int          lat_cfg    = 1;
    bit          silent_cfg = 0;
    int          drop_cfg   = 0;
    logic [31:0] rdata_cfg  = '0;
    int          hi_cnt     = 0;
    int          drop_left  = 0;
    int          overlap    = 0;

    io_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T)) dut (
        .io_clk     (io_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .io_addr    (io_addr),
        .io_read    (io_read),
        .io_write   (io_write),
        .io_wdata   (io_wdata),
        .read_ready (read_ready),
        .io_rdata   (io_rdata),
        .io_ready   (io_ready)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    assign io_rdata = rdata_cfg;

    // Responder: raises io_ready lat_cfg cycles after it first sees the strobe, drops it drop_cfg cycles after strobe falls
    initial io_ready = 1'b0;
    always @(negedge io_clk) begin
        if (io_read || io_write) begin
            hi_cnt++;
            drop_left = drop_cfg;
            if (!silent_cfg && hi_cnt > lat_cfg) io_ready = 1'b1;
        end else begin
            hi_cnt = 0;
            if (io_ready && drop_left > 0) drop_left--;
            else io_ready = 1'b0;
        end
        if (io_read && io_write) overlap++;
    end

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdat, input int lat, input bit silent,
                           input int rr_delay, input int drop, input string tag);
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          exp_rr;
        int          cyc;
        int          rr;
        bit          strobe_ok;
        bit          stable_ok;

        exp_err   = silent || (lat >= T);
        exp_lat   = exp_err ? T + 1 : lat + 2;
        exp_rdata = (!wr && !exp_err) ? rdat : 32'h0;
        exp_rr    = (!wr && !exp_err) ? 1 : 0;

        lat_cfg = lat; silent_cfg = silent; drop_cfg = drop; rdata_cfg = rdat;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready_before: got %b expected 1", tag, req_ready);
        end

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge io_clk); #1;
        req_valid = 1'b0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom;
        cyc = 1;

        checks++;
        if ({io_read, io_write, io_addr, io_wdata} !== {!wr, wr, addr, wdata}) begin
            errors++;
            $display("FAIL %s strobe_setup: got rd=%b wr=%b addr=%h wdata=%h expected rd=%b wr=%b addr=%h wdata=%h",
                     tag, io_read, io_write, io_addr, io_wdata, !wr, wr, addr, wdata);
        end

        strobe_ok = 1'b1;
        rr = 0;
        while (!resp_valid && cyc < 40) begin
            if ({io_read, io_write} !== {!wr, wr} || io_addr !== addr || io_wdata !== wdata || req_ready !== 1'b0)
                strobe_ok = 1'b0;
            if (read_ready === 1'b1) rr++;
            @(posedge io_clk); #1;
            cyc++;
        end
        if (read_ready === 1'b1) rr++;

        checks++;
        if (resp_valid !== 1'b1 || cyc != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got resp_valid=%b at cycle %0d expected 1 at cycle %0d",
                     tag, resp_valid, cyc, exp_lat);
        end
        checks++;
        if (!strobe_ok || io_read !== 1'b0 || io_write !== 1'b0) begin
            errors++;
            $display("FAIL %s strobe_hold_drop: got held_ok=%b rd=%b wr=%b expected 1 0 0",
                     tag, strobe_ok, io_read, io_write);
        end
        checks++;
        if (resp_rdata !== exp_rdata || resp_err !== exp_err) begin
            errors++;
            $display("FAIL %s response: got rdata=%h err=%b expected rdata=%h err=%b",
                     tag, resp_rdata, resp_err, exp_rdata, exp_err);
        end
        checks++;
        if (rr != exp_rr) begin
            errors++;
            $display("FAIL %s read_ready_pulses: got %0d expected %0d", tag, rr, exp_rr);
        end

        stable_ok = 1'b1;
        repeat (rr_delay) begin
            @(posedge io_clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== exp_err ||
                req_ready !== 1'b0 || io_read !== 1'b0 || io_write !== 1'b0 || read_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        if (rr_delay > 0) begin
            checks++;
            if (!stable_ok) begin
                errors++;
                $display("FAIL %s resp_hold: got stable=%b expected 1 (valid=%b rdata=%h req_ready=%b)",
                         tag, stable_ok, resp_valid, resp_rdata, req_ready);
            end
        end

        resp_ready = 1'b1;
        @(posedge io_clk); #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_valid_clear: got %b expected 0", tag, resp_valid);
        end

        cyc = 0;
        while (req_ready !== 1'b1 && cyc < T + 4) begin
            @(posedge io_clk); #1;
            cyc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s back_to_idle: got req_ready=%b expected 1 within %0d cycles", tag, req_ready, T + 4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge io_clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, io_read, io_write, read_ready} !== 6'b100000 ||
            resp_rdata !== 32'h0 || io_addr !== 32'h0 || io_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req_ready=%b resp_valid=%b err=%b rd=%b wr=%b rr=%b rdata=%h addr=%h expected 1 0 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_err, io_read, io_write, read_ready, resp_rdata, io_addr);
        end
        @(negedge io_clk);
        rst = 1'b0;
        @(posedge io_clk); #1;
        checks++;
        if (req_ready !== 1'b1 || io_read !== 1'b0 || io_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got req_ready=%b rd=%b wr=%b expected 1 0 0", req_ready, io_read, io_write);
        end
    endtask

    task automatic test_write();
        run_txn(1'b1, 32'(GPIO_SET_OFS), 32'h0000_00A5, 32'hDEAD_BEEF, 1, 1'b0, 0, 0, "write");
    endtask

    task automatic test_read();
        run_txn(1'b0, 32'(GPIO_READ_OFS), 32'h1234_5678, 32'h0000_005A, 1, 1'b0, 0, 0, "read");
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'(GPIO_INT_READ_OFS), 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 0, 0, "timeout_silent");
        run_txn(1'b0, 32'(GPIO_CONFIG_OFS), 32'h0, 32'h0000_0C3C, T - 1, 1'b0, 0, 0, "ready_wins_last_cycle");
        run_txn(1'b1, 32'(GPIO_INT_CLEAR_OFS), 32'h0000_0001, 32'h0, T, 1'b0, 0, 1, "timeout_late_ready");
    endtask

    task automatic test_resp_stall();
        run_txn(1'b0, 32'(GPIO_READ_OFS), 32'h0, 32'hCAFE_0042, 2, 1'b0, 5, 0, "resp_stall");
        run_txn(1'b0, 32'(GPIO_READ_OFS), 32'h0, 32'h0000_7777, 1, 1'b0, 0, 3, "recover_hold");
    endtask

    task automatic test_back_to_back();
        overlap = 0;
        run_txn(1'b0, 32'h0000_0100, 32'h0, 32'h1111_2222, 1, 1'b0, 0, 0, "b2b_first");
        run_txn(1'b0, 32'h0000_0104, 32'h0, 32'h3333_4444, 1, 1'b0, 0, 0, "b2b_second");
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL b2b_strobe_overlap: got %0d cycles with both strobes expected 0", overlap);
        end
    endtask

    task automatic test_random();
        overlap = 0;
        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    $urandom_range(1, T + 1), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", i));
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL rand_strobe_overlap: got %0d expected 0", overlap);
        end
    endtask

    task automatic test_reset_mid_access();
        lat_cfg = 4; silent_cfg = 1'b0; drop_cfg = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55;
        @(posedge io_clk); #1;
        req_valid = 1'b0;
        checks++;
        if (io_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: got io_write=%b expected 1", io_write);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (io_write !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: got io_write=%b resp_valid=%b req_ready=%b expected 0 0 1",
                     io_write, resp_valid, req_ready);
        end
        @(negedge io_clk);
        rst = 1'b0;
        @(posedge io_clk); #1;
        checks++;
        if (req_ready !== 1'b1 || io_write !== 1'b0 || io_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: got req_ready=%b wr=%b rd=%b expected 1 0 0", req_ready, io_write, io_read);
        end
        run_txn(1'b0, 32'h48, 32'h0, 32'h0000_ABCD, 3, 1'b0, 1, 0, "after_reset");
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_resp_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no finish by 200000 expected earlier finish");
        $fatal(1, "watchdog");
    end

endmodule
